// File: rtl/ds_sample_scheduler.sv
// Sample scheduler for the delta-sigma PWM: FIFO-buffered samples released every 2^div pulses.
// Define DS_SCHED_INTERP_EN to build linear interpolation instead of zero-order hold.
module ds_sample_scheduler #(
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned FIFO_LOG2   = 3,
  parameter int unsigned FILL_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   wr_valid,
  input  logic [SAMPLE_BITS-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   pulse_done,
  input  logic [3:0]             div_log2,
  output logic [SAMPLE_BITS-1:0] u_out,
  output logic                   sample_tick,
  output logic [FIFO_LOG2:0]     fifo_level,
  output logic                   underrun,
  input  logic                   clear_underrun
);

  localparam int unsigned Depth = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] LevelFull = (FIFO_LOG2 + 1)'(Depth);
  localparam logic [FIFO_LOG2:0] LevelThresh = (FIFO_LOG2 + 1)'(FILL_THRESH);
  localparam logic [SAMPLE_BITS-1:0] Midscale = {1'b1, {(SAMPLE_BITS - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e                 state_q;
  logic [FIFO_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG2:0]     level_q;
  logic [7:0]             cnt_q;
  logic [3:0]             div_q;
  logic [SAMPLE_BITS-1:0] u_q;
  logic                   tick_q;
  logic                   und_q;
  logic [SAMPLE_BITS-1:0] mem_q [Depth];

  logic [3:0]             div_clamp;
  logic [8:0]             period_mask;
  logic                   fifo_empty, push, period_end, tick, pop, und_set;
  logic [SAMPLE_BITS-1:0] head;

`ifdef DS_SCHED_INTERP_EN
  logic [SAMPLE_BITS-1:0]        target_q;
  logic signed [SAMPLE_BITS:0]   step_q;
  logic signed [SAMPLE_BITS:0]   step_new;
  logic signed [SAMPLE_BITS+1:0] sum;
  logic [SAMPLE_BITS-1:0]        u_sat;
`endif

  always_comb begin
    div_clamp   = (div_log2 > 4'd8) ? 4'd8 : div_log2;
    period_mask = (9'd1 << div_q) - 9'd1;
    fifo_empty  = (level_q == '0);
    wr_ready    = (level_q != LevelFull);
    push        = wr_valid && wr_ready;
    period_end  = pulse_done && ({1'b0, cnt_q} == period_mask);
    tick        = enable && (state_q == StRun) && period_end;
    // Flush wins over a tick pop; an empty tick still counts as an underrun.
    pop         = tick && !fifo_empty && !flush;
    und_set     = tick && fifo_empty;
    head        = mem_q[rd_ptr_q];
`ifdef DS_SCHED_INTERP_EN
    step_new = ($signed({1'b0, head}) - $signed({1'b0, target_q})) >>> div_clamp;
    sum      = $signed({2'b00, u_q}) + $signed({step_q[SAMPLE_BITS], step_q});
    if (sum[SAMPLE_BITS+1]) begin
      u_sat = '0;
    end else if (sum[SAMPLE_BITS]) begin
      u_sat = '1;
    end else begin
      u_sat = sum[SAMPLE_BITS-1:0];
    end
`endif
  end

  assign u_out       = u_q;
  assign sample_tick = tick_q;
  assign fifo_level  = level_q;
  assign underrun    = und_q;

  // Storage needs no reset: level and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      u_q      <= Midscale;
      tick_q   <= 1'b0;
      und_q    <= 1'b0;
`ifdef DS_SCHED_INTERP_EN
      target_q <= Midscale;
      step_q   <= '0;
`endif
    end else begin
      tick_q <= pop;

      if (und_set) begin
        und_q <= 1'b1;
      end else if (clear_underrun) begin
        und_q <= 1'b0;
      end

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop) level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end

      if (!enable) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StFill;
            cnt_q   <= '0;
          end
          StFill: begin
            if (level_q >= LevelThresh) begin
              state_q <= StRun;
              cnt_q   <= '0;
              div_q   <= div_clamp;
            end
          end
          StRun: begin
            if (period_end) begin
              cnt_q <= '0;
              div_q <= div_clamp;
              if (fifo_empty) state_q <= StFill;
            end else if (pulse_done) begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

`ifdef DS_SCHED_INTERP_EN
      if (pop) begin
        u_q      <= target_q;
        target_q <= head;
        step_q   <= step_new;
      end else if (und_set) begin
        u_q    <= target_q;
        step_q <= '0;
      end else if (enable && (state_q == StRun) && pulse_done && !tick) begin
        u_q <= u_sat;
      end
`else
      if (pop) u_q <= head;
`endif
    end
  end

endmodule

// File: tb/tb_ds_sample_scheduler.sv
// Self-checking bench for ds_sample_scheduler: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ds_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        pulse_done = 1'b0;
  logic [3:0]  div_log2 = '0;
  logic [15:0] u_out;
  logic        sample_tick;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic        clear_underrun = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 idle, 1 fill, 2 run.
  int          m_mode, m_cnt, m_div;
  logic [15:0] m_u;
  logic        m_tick, m_und;
  logic [15:0] m_q[$];

  always #5 clk = ~clk;

  ds_sample_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .pulse_done     (pulse_done),
    .div_log2       (div_log2),
    .u_out          (u_out),
    .sample_tick    (sample_tick),
    .fifo_level     (fifo_level),
    .underrun       (underrun),
    .clear_underrun (clear_underrun)
  );

  function automatic int clamp8(input logic [3:0] d);
    return (d > 4'd8) ? 8 : int'(d);
  endfunction

  // Four idle cycles, then one pulse; returns at the negedge after the sampling edge.
  task automatic send_pulse();
    repeat (4) @(negedge clk);
    pulse_done = 1'b1;
    @(negedge clk);
    pulse_done = 1'b0;
  endtask

  task automatic model_step();
    bit push, pop, und_set;
    push    = wr_valid && (m_q.size() != 8);
    pop     = 1'b0;
    und_set = 1'b0;
    if (!enable) begin
      m_mode = 0;
      m_cnt  = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_cnt  = 0;
    end else if (m_mode == 1) begin
      if (m_q.size() >= 2) begin
        m_mode = 2;
        m_cnt  = 0;
        m_div  = clamp8(div_log2);
      end
    end else if (pulse_done) begin
      if (m_cnt == (1 << m_div) - 1) begin
        m_cnt = 0;
        m_div = clamp8(div_log2);
        if (m_q.size() == 0) begin
          und_set = 1'b1;
          m_mode  = 1;
        end else if (!flush) begin
          pop = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
    m_tick = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) begin
        m_u    = m_q.pop_front();
        m_tick = 1'b1;
      end
      if (push) m_q.push_back(wr_data);
    end
    if (und_set) m_und = 1'b1;
    else if (clear_underrun) m_und = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0; flush = 1'b0; wr_valid = 1'b0; pulse_done = 1'b0; clear_underrun = 1'b0;
    #1;
    checks++;
    if (u_out !== 16'h8000) begin
      errors++; $display("FAIL reset_u_out: got %h expected 8000", u_out);
    end
    checks++;
    if (fifo_level !== 4'd0) begin
      errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level);
    end
    checks++;
    if (wr_ready !== 1'b1 || underrun !== 1'b0 || sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b und=%b tick=%b expected 1 0 0",
               wr_ready, underrun, sample_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 0; m_cnt = 0; m_div = 0; m_u = 16'h8000; m_tick = 1'b0; m_und = 1'b0;
    m_q.delete();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'($urandom);
      @(negedge clk);
      if (i == 7) begin
        checks++;
        if (fifo_level !== 4'd8 || wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL fifo_full: got level=%0d rdy=%b expected 8 0", fifo_level, wr_ready);
        end
      end
    end
    wr_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd8) begin
      errors++; $display("FAIL fifo_overflow_drop: got level=%0d expected 8", fifo_level);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (fifo_level !== 4'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_flush: got level=%0d rdy=%b expected 0 1", fifo_level, wr_ready);
    end
  endtask

  task automatic test_hold_stream();
    int ticks;
    div_log2 = 4'd2;
    wr_valid = 1'b1; wr_data = 16'h1000;
    @(negedge clk);
    wr_data = 16'h2000;
    @(negedge clk);
    wr_valid = 1'b0;
    enable   = 1'b1;
    repeat (2) @(negedge clk);
    ticks = 0;
    for (int p = 1; p <= 12; p++) begin
      send_pulse();
      ticks += int'(sample_tick);
      if (p == 3) begin
        checks++;
        if (u_out !== 16'h8000) begin
          errors++; $display("FAIL hold_before_tick: got %h expected 8000", u_out);
        end
      end
      if (p == 4) begin
        checks++;
        if (u_out !== 16'h1000 || sample_tick !== 1'b1) begin
          errors++;
          $display("FAIL hold_tick1: got u=%h tick=%b expected 1000 1", u_out, sample_tick);
        end
      end
      if (p == 8) begin
        checks++;
        if (u_out !== 16'h2000) begin
          errors++; $display("FAIL hold_tick2: got %h expected 2000", u_out);
        end
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++; $display("FAIL hold_tick_count: got %0d expected 2", ticks);
    end
    checks++;
    if (underrun !== 1'b1 || u_out !== 16'h2000 || fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL underrun_set: got und=%b u=%h level=%0d expected 1 2000 0",
               underrun, u_out, fifo_level);
    end
  endtask

  task automatic test_underrun_recover();
    clear_underrun = 1'b1;
    wr_valid = 1'b1; wr_data = 16'h3000;
    @(negedge clk);
    clear_underrun = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (underrun !== 1'b0 || fifo_level !== 4'd1) begin
      errors++;
      $display("FAIL underrun_clear: got und=%b level=%0d expected 0 1", underrun, fifo_level);
    end
    // Below threshold the block must sit in FILL and ignore pulses.
    for (int p = 0; p < 4; p++) send_pulse();
    checks++;
    if (fifo_level !== 4'd1 || u_out !== 16'h2000) begin
      errors++;
      $display("FAIL fill_ignores_pulses: got level=%0d u=%h expected 1 2000", fifo_level, u_out);
    end
    wr_valid = 1'b1; wr_data = 16'h4000;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    for (int p = 1; p <= 4; p++) begin
      send_pulse();
      if (p == 3) begin
        checks++;
        if (u_out !== 16'h2000) begin
          errors++; $display("FAIL rerun_early: got %h expected 2000", u_out);
        end
      end
    end
    checks++;
    if (u_out !== 16'h3000 || fifo_level !== 4'd1) begin
      errors++;
      $display("FAIL rerun_tick: got u=%h level=%0d expected 3000 1", u_out, fifo_level);
    end
  endtask

  task automatic test_simultaneous();
    enable = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 16'h5000;
    @(negedge clk);
    wr_data = 16'h6000;
    @(negedge clk);
    wr_valid = 1'b0;
    div_log2 = 4'd0;
    enable   = 1'b1;
    repeat (2) @(negedge clk);
    pulse_done = 1'b1;
    wr_valid = 1'b1; wr_data = 16'h7000;
    @(negedge clk);
    pulse_done = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd3 || sample_tick !== 1'b1 || u_out !== 16'h4000) begin
      errors++;
      $display("FAIL push_pop_same_cycle: got level=%0d tick=%b u=%h expected 3 1 4000",
               fifo_level, sample_tick, u_out);
    end
    flush = 1'b1;
    wr_valid = 1'b1; wr_data = 16'h1234;
    @(negedge clk);
    flush = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd0) begin
      errors++; $display("FAIL push_with_flush: got level=%0d expected 0", fifo_level);
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      checks++;
      if (u_out !== m_u || sample_tick !== m_tick || fifo_level !== 4'(m_q.size()) ||
          wr_ready !== (m_q.size() != 8) || underrun !== m_und) begin
        errors++;
        $display("FAIL random_cycle_%0d: got u=%h tick=%b lvl=%0d rdy=%b und=%b expected %h %b %0d %b %b",
                 i, u_out, sample_tick, fifo_level, wr_ready, underrun,
                 m_u, m_tick, m_q.size(), m_q.size() != 8, m_und);
      end
      enable         = ($urandom_range(0, 39) != 0);
      flush          = ($urandom_range(0, 31) == 0);
      wr_valid       = ($urandom_range(0, 2) != 0);
      wr_data        = 16'($urandom);
      pulse_done     = ($urandom_range(0, 2) == 0);
      clear_underrun = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) begin
        div_log2 = ($urandom_range(0, 49) == 0) ? 4'd9 : 4'($urandom_range(0, 3));
      end
      model_step();
      @(negedge clk);
    end
  endtask

`ifdef DS_SCHED_INTERP_EN
  task automatic test_interp();
    logic [15:0] exp_u;
    div_log2 = 4'd2;
    wr_valid = 1'b1; wr_data = 16'h8000;
    @(negedge clk);
    wr_data = 16'h8400;
    @(negedge clk);
    wr_valid = 1'b0;
    enable   = 1'b1;
    repeat (2) @(negedge clk);
    for (int p = 1; p <= 12; p++) begin
      send_pulse();
      exp_u = 16'h8000;
      if (p >= 9 && p <= 11) exp_u = 16'h8000 + 16'(16'h0100 * (p - 8));
      if (p == 12) exp_u = 16'h8400;
      checks++;
      if (u_out !== exp_u) begin
        errors++; $display("FAIL interp_pulse_%0d: got %h expected %h", p, u_out, exp_u);
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_fifo_full();
`ifdef DS_SCHED_INTERP_EN
    test_interp();
`else
    test_hold_stream();
    test_underrun_recover();
    test_simultaneous();
    test_reset();
    test_random();
`endif
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds_sample_scheduler.md
# ds_sample_scheduler

Sample scheduler that feeds the delta-sigma pulse-width modulator's 16-bit input word. It buffers host-written samples in a small FIFO and releases one sample every 2^div_log2 modulator pulses, counted on the modulator's `pulse_done` strobe. It sits between the register-write path and the modulator `u` input, replacing the direct write to sample register 0 when streaming. It also flags underruns.

## Interface
Parameters:
- `SAMPLE_BITS`, 16: sample width, unsigned offset-binary.
- `FIFO_LOG2`, 3: FIFO depth = 2^FIFO_LOG2 entries.
- `FILL_THRESH`, 2: FIFO level required to leave FILL; legal range 1..2^FIFO_LOG2.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  streaming enable; level-sensitive.
- `flush`  in  1  single-cycle pulse; empties the FIFO.
- `wr_valid`  in  1  host sample valid.
- `wr_data`  in  SAMPLE_BITS  host sample.
- `wr_ready`  out  1  high when the FIFO is not full.
- `pulse_done`  in  1  single-cycle strobe from the modulator, once per pulse.
- `div_log2`  in  4  release period = 2^div_log2 pulses; values above 8 are clamped to 8.
- `u_out`  out  SAMPLE_BITS  sample driven to the modulator; registered.
- `sample_tick`  out  1  single-cycle pulse on each FIFO pop.
- `fifo_level`  out  FIFO_LOG2+1  current FIFO occupancy.
- `underrun`  out  1  sticky underrun flag.
- `clear_underrun`  in  1  single-cycle pulse; clears `underrun`.

## Operation
- FIFO:
  - A push happens when `wr_valid && wr_ready`.
  - `wr_ready` = level != 2^FIFO_LOG2, evaluated on the start-of-cycle level. There is no bypass.
  - A push and a pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo the depth.
  - `flush` clears the level and the pointers. It takes priority over a same-cycle push or pop.
- States: IDLE, FILL, RUN.
  - IDLE: `u_out` held, pulse counter held at 0. Go to FILL when `enable` = 1.
  - FILL: wait for level >= FILL_THRESH, then go to RUN with the pulse counter at 0. Pushes are allowed.
  - RUN: each `pulse_done` increments the 8-bit pulse counter. When `pulse_done` arrives with counter == 2^div_log2 - 1, a tick occurs and the counter returns to 0.
- Tick behaviour:
  - FIFO non-empty: pop the head, `sample_tick` = 1, load `u_out` (see Configuration).
  - FIFO empty: set `underrun`, hold `u_out`, go to FILL. No pop and no `sample_tick`.
- `enable` = 0 in any state: go to IDLE on the next edge. FIFO contents are kept and `u_out` is held.
- `underrun` is set by an empty tick and cleared by `clear_underrun`. If both happen in the same cycle, set wins.
- `div_log2` is sampled at every tick and on entry to RUN. A change mid-period takes effect after the next tick.
- `pulse_done` in IDLE or FILL is ignored.

## Timing
- Reset values: `u_out` = 1 << (SAMPLE_BITS-1) (midscale); state IDLE; level 0; pointers 0; counter 0; `underrun` 0; `sample_tick` 0; `wr_ready` 1.
- A push at edge N is visible in `fifo_level` after edge N.
- Tick latency: the `pulse_done` cycle is sampled at edge N. After edge N, `sample_tick` = 1 for one cycle and `u_out` holds the new value (zero-order-hold build).
- FILL→RUN is one edge after the level reaches FILL_THRESH.
- Asserting `rst_n` low mid-operation returns every output to its reset value immediately. FIFO contents are discarded.

## Configuration
- `DS_SCHED_INTERP_EN` defined: linear interpolation.
  - Extra registers: `target` (reset midscale) and a signed SAMPLE_BITS+1 `step` (reset 0).
  - At a tick: `u_out` <= `target`; `target` <= popped sample; `step` <= (popped - `target`) >>> div_log2, signed arithmetic shift.
  - Each non-tick `pulse_done` in RUN: `u_out` <= `u_out` + `step`, saturating to 0..2^SAMPLE_BITS-1.
  - Samples appear one period later than in the zero-order-hold build.
  - On an underrun: `step` <= 0 and `u_out` <= `target`.
- Not defined: zero-order hold. At a tick, `u_out` <= popped sample. The `target` and `step` registers are absent.

## Test plan
- Reset: `rst_n` low, mid-stream → `u_out` = 0x8000, `fifo_level` = 0, `wr_ready` = 1, `underrun` = 0, state IDLE.
- FIFO full: with `enable` = 0, push 8 samples → `fifo_level` = 8, `wr_ready` = 0. A 9th `wr_valid` is dropped. `flush` → level 0.
- Hold streaming (build without `DS_SCHED_INTERP_EN`): `div_log2` = 2; push 0x1000 and 0x2000; `enable` = 1; issue `pulse_done` every 5 cycles.
  - `u_out` = 0x1000 one edge after the 4th pulse.
  - `u_out` = 0x2000 one edge after the 8th pulse.
  - `sample_tick` asserts twice.
- Underrun: continue the previous scenario to a 12th pulse with an empty FIFO → `underrun` = 1, `u_out` stays 0x2000, state FILL. Then `clear_underrun` together with a push → `underrun` = 0; RUN entered once level >= 2.
- Interpolation (`DS_SCHED_INTERP_EN`): `div_log2` = 2; samples 0x8000 then 0x8400.
  - After the second tick, `u_out` steps 0x8000 → 0x8100 → 0x8200 → 0x8300.
  - At the next tick it snaps to 0x8400.
- Simultaneous events: push and tick pop in the same cycle at level 3 → level stays 3. Push in the same cycle as `flush` → level 0.
